// File: rtl/cfg_reg_master.sv
// cfg_reg_master: register-bus initiator for the CFG register tree.
// Accepts write / read / poll-until-match commands one at a time on a valid/ready
// command stream and returns exactly one response per command.
module cfg_reg_master #(
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned POLL_MAX_TRIES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [63:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic [63:0] reg_addr,
    output logic        reg_wr_en,
    output logic [31:0] reg_wr_data,
    input  logic [31:0] reg_rd_data
);

    // Wait counter only needs to reach RD_LATENCY; keep at least one bit for latency 0.
    localparam int unsigned CntW   = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
    localparam int unsigned TriesW = $clog2(POLL_MAX_TRIES + 1);

    localparam logic [CntW-1:0]   CntLast  = CntW'(RD_LATENCY);
    localparam logic [TriesW-1:0] TriesMax = TriesW'(POLL_MAX_TRIES);

    localparam logic [1:0] OpWrite = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpPoll  = 2'b10;

    localparam logic [1:0] StatusOk      = 2'b00;
    localparam logic [1:0] StatusTimeout = 2'b01;
    localparam logic [1:0] StatusIllegal = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRdWait,
        StResp
    } state_e;

    state_e             state_q, state_d;
    logic               is_poll_q, is_poll_d;
    logic [31:0]        expect_q, expect_d;
    logic [31:0]        mask_q, mask_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [TriesW-1:0]  tries_q, tries_d;
    logic [63:0]        reg_addr_q, reg_addr_d;
    logic [31:0]        reg_wr_data_q, reg_wr_data_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic [1:0]         rsp_status_q, rsp_status_d;
    logic [TriesW-1:0]  tries_inc;
    logic               poll_match;

    // Next-state logic: command capture, read timing, poll retry and response hold.
    always_comb begin
        state_d       = state_q;
        is_poll_d     = is_poll_q;
        expect_d      = expect_q;
        mask_d        = mask_q;
        cnt_d         = cnt_q;
        tries_d       = tries_q;
        reg_addr_d    = reg_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_status_d  = rsp_status_q;
        tries_inc     = tries_q + 1'b1;
        poll_match    = ((reg_rd_data ^ expect_q) & mask_q) == 32'd0;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    is_poll_d  = (cmd_op == OpPoll);
                    expect_d   = cmd_wdata;
                    mask_d     = cmd_mask;
                    reg_addr_d = cmd_addr;
                    cnt_d      = '0;
                    tries_d    = '0;
                    unique case (cmd_op)
                        OpWrite: begin
                            reg_wr_data_d = cmd_wdata;
                            state_d       = StWrite;
                        end
                        OpRead, OpPoll: begin
                            state_d = StRdWait;
                        end
                        default: begin
                            rsp_rdata_d  = 32'd0;
                            rsp_status_d = StatusIllegal;
                            state_d      = StResp;
                        end
                    endcase
                end
            end
            StWrite: begin
                rsp_rdata_d  = 32'd0;
                rsp_status_d = StatusOk;
                state_d      = StResp;
            end
            StRdWait: begin
                if (cnt_q == CntLast) begin
                    rsp_rdata_d = reg_rd_data;
                    tries_d     = tries_inc;
                    if (!is_poll_q || poll_match) begin
                        rsp_status_d = StatusOk;
                        state_d      = StResp;
                    end else if (tries_inc == TriesMax) begin
                        rsp_status_d = StatusTimeout;
                        state_d      = StResp;
                    end else begin
                        // Re-read the same address; reg_addr is left untouched.
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; in-flight commands are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            is_poll_q     <= 1'b0;
            expect_q      <= 32'd0;
            mask_q        <= 32'd0;
            cnt_q         <= '0;
            tries_q       <= '0;
            reg_addr_q    <= 64'd0;
            reg_wr_data_q <= 32'd0;
            rsp_rdata_q   <= 32'd0;
            rsp_status_q  <= 2'b00;
        end else begin
            state_q       <= state_d;
            is_poll_q     <= is_poll_d;
            expect_q      <= expect_d;
            mask_q        <= mask_d;
            cnt_q         <= cnt_d;
            tries_q       <= tries_d;
            reg_addr_q    <= reg_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_status_q  <= rsp_status_d;
        end
    end

    assign cmd_ready   = (state_q == StIdle);
    assign rsp_valid   = (state_q == StResp);
    // Gate the strobe with rst so no write reaches the register tree once reset is seen.
    assign reg_wr_en   = (state_q == StWrite) && !rst;
    assign reg_addr    = reg_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_status  = rsp_status_q;

endmodule

// File: tb/tb_cfg_reg_master.sv
// Self-checking bench for cfg_reg_master: the bench plays the register responder,
// driving random data except in the exact cycles where a read must be sampled.
module tb_cfg_reg_master;

    localparam int RdLat    = 1;
    localparam int MaxTries = 4;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [63:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [31:0] cmd_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic [63:0] reg_addr;
    logic        reg_wr_en;
    logic [31:0] reg_wr_data;
    logic [31:0] reg_rd_data;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] last_addr;
    logic [31:0] last_wr;
    logic [31:0] rd_seq [MaxTries];

    cfg_reg_master #(
        .RD_LATENCY     (RdLat),
        .POLL_MAX_TRIES (MaxTries)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_mask    (cmd_mask),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_status  (rsp_status),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_data (reg_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one command and check every cycle until its response handshake.
    // abort_j > 0 asserts rst in that cycle after acceptance and expects no response.
    task automatic run_cmd(input logic [1:0] op, input logic [63:0] addr,
                           input logic [31:0] wdata, input logic [31:0] mask,
                           input int stall, input int abort_j);
        int          n;
        int          rsp_j;
        int          total;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_status;
        logic [2:0]  got_flags;
        logic [2:0]  exp_flags;
        logic [31:0] exp_wr;
        logic [132:0] got_rst;
        logic [132:0] exp_rst;

        // Reference model: number of tries, response cycle and response contents.
        n = 1;
        case (op)
            2'b00: begin rsp_j = 2; exp_rdata = 32'd0; exp_status = 2'b00; end
            2'b01: begin rsp_j = RdLat + 2; exp_rdata = rd_seq[0]; exp_status = 2'b00; end
            2'b10: begin
                n = MaxTries;
                exp_status = 2'b01;
                for (int k = 1; k <= MaxTries; k++) begin
                    if (exp_status == 2'b01 && ((rd_seq[k-1] ^ wdata) & mask) == 32'd0) begin
                        n = k;
                        exp_status = 2'b00;
                    end
                end
                exp_rdata = rd_seq[n-1];
                rsp_j = n * (RdLat + 1) + 1;
            end
            default: begin rsp_j = 1; exp_rdata = 32'd0; exp_status = 2'b10; end
        endcase
        total  = rsp_j + stall;
        exp_wr = (op == 2'b00) ? wdata : last_wr;

        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_before_cmd: cmd_ready=%b rsp_valid=%b, required 1 and 0",
                     cmd_ready, rsp_valid);
        end
        vectors++;
        if (reg_addr !== last_addr || reg_wr_data !== last_wr) begin
            miscompares++;
            $display("FAIL idle_hold: reg_addr=%h reg_wr_data=%h, required %h %h",
                     reg_addr, reg_wr_data, last_addr, last_wr);
        end
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_addr    = addr;
        cmd_wdata   = wdata;
        cmd_mask    = mask;
        rsp_ready   = 1'($urandom);
        reg_rd_data = $urandom;
        @(posedge clk);

        for (int j = 1; j <= total; j++) begin
            @(negedge clk);
            // While busy, present garbage commands that must not be accepted.
            cmd_valid = 1'($urandom);
            cmd_op    = 2'($urandom);
            cmd_addr  = {$urandom, $urandom};
            cmd_wdata = $urandom;
            cmd_mask  = $urandom;

            if (j == abort_j) begin
                rst = 1'b1;
                cmd_valid = 1'b0;
                #1;
                vectors++;
                if (reg_wr_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL strobe_during_reset: reg_wr_en=%b, required 0", reg_wr_en);
                end
                @(negedge clk);
                rst = 1'b0;
                got_rst = {cmd_ready, rsp_valid, reg_wr_en, rsp_status, rsp_rdata,
                           reg_addr, reg_wr_data};
                exp_rst = {1'b1, 132'd0};
                vectors++;
                if (got_rst !== exp_rst) begin
                    miscompares++;
                    $display("FAIL reset_values: got %h, required %h", got_rst, exp_rst);
                end
                last_addr = 64'd0;
                last_wr   = 32'd0;
                for (int k = 0; k < 2 * (RdLat + 1) + 2; k++) begin
                    @(negedge clk);
                    reg_rd_data = $urandom;
                    vectors++;
                    if ({cmd_ready, rsp_valid, reg_wr_en} !== 3'b100) begin
                        miscompares++;
                        $display("FAIL dropped_after_reset: ready/valid/wr_en=%b, required 100",
                                 {cmd_ready, rsp_valid, reg_wr_en});
                    end
                end
                return;
            end

            exp_flags = {1'b0, 1'(j >= rsp_j), 1'(op == 2'b00 && j == 1)};
            got_flags = {cmd_ready, rsp_valid, reg_wr_en};
            vectors++;
            if (got_flags !== exp_flags) begin
                miscompares++;
                $display("FAIL handshake_flags op=%0d cyc=T+%0d: ready/valid/wr_en=%b, required %b",
                         op, j, got_flags, exp_flags);
            end
            vectors++;
            if (reg_addr !== addr || reg_wr_data !== exp_wr) begin
                miscompares++;
                $display("FAIL reg_bus op=%0d cyc=T+%0d: addr=%h wdata=%h, required %h %h",
                         op, j, reg_addr, reg_wr_data, addr, exp_wr);
            end
            if (j >= rsp_j) begin
                vectors++;
                if (rsp_rdata !== exp_rdata || rsp_status !== exp_status) begin
                    miscompares++;
                    $display("FAIL response op=%0d cyc=T+%0d: rdata=%h status=%b, required %h %b",
                             op, j, rsp_rdata, rsp_status, exp_rdata, exp_status);
                end
            end

            // Responder: valid data only in the cycle each try is sampled.
            if ((op == 2'b01 || op == 2'b10) && (j % (RdLat + 1)) == 0 &&
                (j / (RdLat + 1)) <= n) begin
                reg_rd_data = rd_seq[j/(RdLat+1) - 1];
            end else begin
                reg_rd_data = $urandom;
            end
            if (j < rsp_j) rsp_ready = 1'($urandom);
            else           rsp_ready = (j == total);
        end
        @(posedge clk);
        last_addr = addr;
        last_wr   = exp_wr;
    endtask

    task automatic test_reset();
        logic [132:0] got;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        got = {cmd_ready, rsp_valid, reg_wr_en, rsp_status, rsp_rdata, reg_addr, reg_wr_data};
        vectors++;
        if (got !== {1'b1, 132'd0}) begin
            miscompares++;
            $display("FAIL test_reset: outputs %h, required %h", got, {1'b1, 132'd0});
        end
        rst = 1'b0;
        last_addr = 64'd0;
        last_wr   = 32'd0;
    endtask

    task automatic test_write();
        run_cmd(2'b00, 64'h0000_0000_0000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0);
    endtask

    task automatic test_read();
        rd_seq[0] = 32'h1234_5678;
        run_cmd(2'b01, 64'h8, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic test_poll_match();
        rd_seq[0] = 32'h0;
        rd_seq[1] = 32'h0;
        rd_seq[2] = 32'h1;
        rd_seq[3] = $urandom;
        run_cmd(2'b10, 64'h10, 32'h1, 32'h1, 0, 0);
    endtask

    task automatic test_poll_timeout();
        rd_seq[0] = 32'h11;
        rd_seq[1] = 32'h22;
        rd_seq[2] = 32'h33;
        rd_seq[3] = 32'hAA;
        run_cmd(2'b10, 64'h18, 32'h55, 32'hFF, 0, 0);
    endtask

    task automatic test_illegal();
        run_cmd(2'b11, {$urandom, $urandom}, $urandom, $urandom, 0, 0);
    endtask

    task automatic test_stall();
        rd_seq[0] = $urandom;
        run_cmd(2'b01, {$urandom, $urandom}, $urandom, $urandom, 10, 0);
        run_cmd(2'b00, {$urandom, $urandom}, $urandom, $urandom, 10, 0);
    endtask

    task automatic test_poll_mask0();
        for (int i = 0; i < MaxTries; i++) rd_seq[i] = $urandom;
        run_cmd(2'b10, {$urandom, $urandom}, $urandom, 32'h0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] mask;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < MaxTries; k++) rd_seq[k] = $urandom;
            case ($urandom % 3)
                0:       mask = 32'h0;
                1:       mask = 32'h1 << ($urandom % 32);
                default: mask = (32'h1 << ($urandom % 32)) | (32'h1 << ($urandom % 32));
            endcase
            run_cmd(2'($urandom), {$urandom, $urandom}, $urandom, mask,
                    int'($urandom % 4), 0);
        end
    endtask

    task automatic test_reset_mid_poll();
        rd_seq[0] = 32'h0;
        rd_seq[1] = 32'h0;
        rd_seq[2] = 32'h0;
        rd_seq[3] = 32'h0;
        run_cmd(2'b10, 64'hCAFE_0000_0000_0020, 32'h1, 32'h1, 0, 5);
    endtask

    task automatic test_reset_mid_write();
        run_cmd(2'b00, 64'h0000_0000_0000_0040, 32'h0BAD_F00D, 32'h0, 0, 1);
        // A clean command must still work after the aborted one.
        run_cmd(2'b00, 64'h0000_0000_0000_0044, 32'h600D_F00D, 32'h0, 0, 0);
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_addr    = 64'd0;
        cmd_wdata   = 32'd0;
        cmd_mask    = 32'd0;
        rsp_ready   = 1'b0;
        reg_rd_data = 32'd0;
        last_addr   = 64'd0;
        last_wr     = 32'd0;
        for (int i = 0; i < MaxTries; i++) rd_seq[i] = 32'd0;

        test_reset();
        test_write();
        test_read();
        test_poll_match();
        test_poll_timeout();
        test_illegal();
        test_stall();
        test_poll_mask0();
        test_back_to_back();
        test_reset_mid_poll();
        test_reset_mid_write();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
